// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_div_unit_pkg : op encodings, FSM states, default widths        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package mul_div_unit_pkg;

    localparam int DEFAULT_WIDTH_DATA  = 32;
    localparam int DEFAULT_WIDTH_MDSEL = 3;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op_is_div(input md_op_t op);
        return op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_div_step : one radix-2 shift-add (mul) / restoring (div) step  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mul_div_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    // Multiply: {hi,lo} holds partial product with the multiplier in lo.
    assign w_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);

    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    // The true difference is below the divisor, so the low WIDTH bits suffice.
    assign w_shifted = {hi, lo[WIDTH-1]};
    assign w_fits    = (w_shifted >= {1'b0, operand});
    assign w_diff    = w_shifted[WIDTH-1:0] - operand;

    always_comb begin
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            hi_next = w_fits ? w_diff : w_shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], w_fits};
        end else begin
            hi_next = w_sum[WIDTH:1];
            lo_next = {w_sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_div_unit : iterative RV-style multiply/divide, fixed latency   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH_DATA_LENGTH  = DEFAULT_WIDTH_DATA,
    parameter int WIDTH_MDSEL_LENGTH = DEFAULT_WIDTH_MDSEL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Start,
    input  logic                          Flush,
    input  logic [WIDTH_MDSEL_LENGTH-1:0] MDSel,
    input  logic [WIDTH_DATA_LENGTH-1:0]  DataA,
    input  logic [WIDTH_DATA_LENGTH-1:0]  DataB,
    output logic                          Busy,
    output logic                          Valid,
    output logic [WIDTH_DATA_LENGTH-1:0]  DataOut
);

    localparam int W     = WIDTH_DATA_LENGTH;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(W);
    localparam logic [W-1:0]     c_most_neg = {1'b1, {(W-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_next;
    md_op_t           r_op;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic [W-1:0]     r_dout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [W-1:0]     w_mag_a;
    logic [W-1:0]     w_mag_b;
    logic [W-1:0]     w_hi_next;
    logic [W-1:0]     w_lo_next;
    logic [2*W-1:0]   w_prod;
    logic [2*W-1:0]   w_prod_fix;
    logic [W-1:0]     w_quo_fix;
    logic [W-1:0]     w_rem_fix;
    logic             w_div_zero;
    logic             w_overflow;
    logic [W-1:0]     w_result;

    // Operand signedness decoded from the captured op.
    assign w_is_div   = op_is_div(r_op);
    assign w_a_signed = (r_op == OP_MULH) || (r_op == OP_MULHSU) ||
                        (r_op == OP_DIV)  || (r_op == OP_REM);
    assign w_b_signed = (r_op == OP_MULH) || (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_neg_a    = w_a_signed & r_a[W-1];
    assign w_neg_b    = w_b_signed & r_b[W-1];
    assign w_mag_a    = w_neg_a ? -r_a : r_a;
    assign w_mag_b    = w_neg_b ? -r_b : r_b;

    mul_div_step #(
        .WIDTH (W)
    ) u_step (
        .is_div  (w_is_div),
        .hi      (r_hi),
        .lo      (r_lo),
        .operand (w_mag_b),
        .hi_next (w_hi_next),
        .lo_next (w_lo_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (Start) w_state_next = ST_CALC;
            ST_CALC: begin
                if (Flush)                   w_state_next = ST_IDLE;
                else if (r_cnt == c_cnt_last) w_state_next = ST_FIX;
            end
            ST_FIX:  w_state_next = Flush ? ST_IDLE : ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // First CALC cycle (count 0) loads magnitudes; counts 1..W are the steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_MUL;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_dout <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_op  <= md_op_t'(3'(MDSel));
                        r_a   <= DataA;
                        r_b   <= DataB;
                        r_cnt <= '0;
                    end
                end
                ST_CALC: begin
                    if (!Flush) begin
                        if (r_cnt == '0) begin
                            r_hi <= '0;
                            r_lo <= w_mag_a;
                        end else begin
                            r_hi <= w_hi_next;
                            r_lo <= w_lo_next;
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!Flush) r_dout <= w_result;
                end
                default: ;
            endcase
        end
    end

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = (w_neg_a ^ w_neg_b) ? -w_prod : w_prod;
    assign w_quo_fix  = (w_neg_a ^ w_neg_b) ? -r_lo : r_lo;
    assign w_rem_fix  = w_neg_a ? -r_hi : r_hi;
    assign w_div_zero = (r_b == '0);
    assign w_overflow = (r_a == c_most_neg) && (r_b == '1);

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_MUL:    w_result = w_prod_fix[W-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  w_result = w_prod_fix[2*W-1:W];
            OP_DIV:    w_result = w_div_zero ? '1 : (w_overflow ? r_a : w_quo_fix);
            OP_DIVU:   w_result = w_div_zero ? '1 : r_lo;
            OP_REM:    w_result = w_div_zero ? r_a : (w_overflow ? '0 : w_rem_fix);
            OP_REMU:   w_result = w_div_zero ? r_a : r_hi;
            default:   w_result = '0;
        endcase
    end

    assign Busy    = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign Valid   = (r_state == ST_DONE);
    assign DataOut = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mul_div_unit : directed vectors for mul_div_unit                |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        Start;
    logic        Flush;
    logic [2:0]  MDSel;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic        Busy;
    logic        Valid;
    logic [31:0] DataOut;

    int tests = 0;
    int fails = 0;

    mul_div_unit #(
        .WIDTH_DATA_LENGTH  (32),
        .WIDTH_MDSEL_LENGTH (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Start   (Start),
        .Flush   (Flush),
        .MDSel   (MDSel),
        .DataA   (DataA),
        .DataB   (DataB),
        .Busy    (Busy),
        .Valid   (Valid),
        .DataOut (DataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE and check both the exact latency and the result.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int lat;
        @(posedge clk);
        @(negedge clk);
        MDSel = op; DataA = a; DataB = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        lat = 0;
        while (Valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd34);
        chk(tag, DataOut, exp);
    endtask

    initial begin
        int pulses;
        int first_at;
        rst = 1'b1; Start = 1'b0; Flush = 1'b0; MDSel = '0; DataA = '0; DataB = '0;
        #12;
        chk("reset Busy", {31'd0, Busy}, 32'd0);
        chk("reset Valid", {31'd0, Valid}, 32'd0);
        chk("reset DataOut", DataOut, 32'd0);
        #11 rst = 1'b0;

        run_op("MUL 100*456",       3'd0, 32'd100, 32'd456, 32'h0000_B220);
        run_op("DIV -100/-1235",    3'd4, -32'sd100, -32'sd1235, 32'h0000_0000);
        run_op("REM -100/-1235",    3'd6, -32'sd100, -32'sd1235, 32'hFFFF_FF9C);
        run_op("MULH -100*-1235",   3'd1, -32'sd100, -32'sd1235, 32'h0000_0000);
        run_op("MULHU ffff*ffff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("MULHSU ffff*ffff",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("MUL ffff*ffff",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("DIVU 7/0",          3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_op("REMU 7/0",          3'd7, 32'd7, 32'd0, 32'h0000_0007);
        run_op("DIV ovf",           3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("REM ovf",           3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("DIV -5/0",          3'd4, -32'sd5, 32'd0, 32'hFFFF_FFFF);
        run_op("REM -5/0",          3'd6, -32'sd5, 32'd0, 32'hFFFF_FFFB);
        run_op("DIV -7/2",          3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD);
        run_op("REM -7/2",          3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF);
        run_op("DIV 7/-2",          3'd4, 32'd7, -32'sd2, 32'hFFFF_FFFD);
        run_op("REM 7/-2",          3'd6, 32'd7, -32'sd2, 32'h0000_0001);
        run_op("DIVU ffff/3",       3'd5, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
        run_op("REMU ffff/10",      3'd7, 32'hFFFF_FFFF, 32'd10, 32'h0000_0005);
        run_op("MUL -3*5",          3'd0, -32'sd3, 32'd5, 32'hFFFF_FFF1);
        run_op("MULH -3*5",         3'd1, -32'sd3, 32'd5, 32'hFFFF_FFFF);
        run_op("MULHSU 2*8000",     3'd2, 32'd2, 32'h8000_0000, 32'h0000_0001);
        run_op("MULH 2*8000",       3'd1, 32'd2, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush in CALC cycle 10: no Valid, DataOut keeps the last result.
        @(posedge clk);
        @(negedge clk);
        MDSel = 3'd0; DataA = 32'd3; DataB = 32'd3; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("flush Busy in CALC", {31'd0, Busy}, 32'd1);
        repeat (9) @(posedge clk);
        #1 Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        chk("flush Busy", {31'd0, Busy}, 32'd0);
        chk("flush Valid", {31'd0, Valid}, 32'd0);
        chk("flush DataOut", DataOut, 32'hFFFF_FFFF);
        run_op("MUL after flush", 3'd0, 32'd12, 32'd13, 32'd156);

        // Async reset at CALC cycle 20.
        @(posedge clk);
        @(negedge clk);
        MDSel = 3'd0; DataA = 32'd5; DataB = 32'd7; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst Busy", {31'd0, Busy}, 32'd0);
        chk("rst Valid", {31'd0, Valid}, 32'd0);
        chk("rst DataOut", DataOut, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Start held through Busy and DONE: exactly one Valid pulse.
        MDSel = 3'd0; DataA = 32'd6; DataB = 32'd7; Start = 1'b1;
        @(posedge clk); #1;
        pulses = 0;
        first_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (Valid === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
            if (i == 35) begin
                chk("Start in DONE ignored", {31'd0, Busy}, 32'd0);
                Start = 1'b0;
            end
        end
        chk("held Start pulses", 32'(pulses), 32'd1);
        chk("held Start latency", 32'(first_at), 32'd34);
        chk("held Start DataOut", DataOut, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH_DATA_LENGTH, default 32, operand/result width.
REQ-002 The block SHALL have parameter WIDTH_MDSEL_LENGTH, default 3, operation-select width.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port Start, input, 1, request to begin an operation.
REQ-006 The block SHALL have port Flush, input, 1, abort the in-flight operation.
REQ-007 The block SHALL have port MDSel, input, WIDTH_MDSEL_LENGTH, operation code.
REQ-008 The block SHALL have ports DataA and DataB, input, WIDTH_DATA_LENGTH, operands (A = multiplicand/dividend, B = multiplier/divisor).
REQ-009 The block SHALL have port Busy, output, 1, operation in progress.
REQ-010 The block SHALL have port Valid, output, 1, one-cycle result strobe.
REQ-011 The block SHALL have port DataOut, output, WIDTH_DATA_LENGTH, result, registered.

Function
REQ-012 MDSel encodings SHALL be: 0 MUL (low word), 1 MULH (signed x signed, high), 2 MULHSU (signed A x unsigned B, high), 3 MULHU (high), 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-013 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 IDLE SHALL go to CALC on Start=1; DataA, DataB and MDSel SHALL be captured on that edge.
REQ-015 CALC SHALL perform one radix-2 step per cycle on magnitudes for exactly WIDTH_DATA_LENGTH cycles, then go to FIX.
REQ-016 FIX SHALL apply the sign correction and the special cases, load DataOut, and go to DONE.
REQ-017 DONE SHALL last one cycle with Valid=1, then return to IDLE.
REQ-018 Latency SHALL be fixed: with Start sampled at edge E, Valid=1 in the cycle after edge E+WIDTH_DATA_LENGTH+2 (34 cycles at the default width), for every op and operand value.
REQ-019 Busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-020 Start SHALL be ignored outside IDLE; captured operands SHALL not change mid-operation.
REQ-021 Start in DONE SHALL be ignored; a new operation may start on the first IDLE cycle.
REQ-022 Flush=1 in CALC or FIX SHALL go to IDLE on the next edge with no Valid pulse, leaving DataOut unchanged.
REQ-023 Flush in IDLE or DONE SHALL have no effect; Flush has priority over Start.
REQ-024 DataOut SHALL hold its last value until the next FIX.
REQ-025 Divide by zero: DIV/DIVU SHALL return all-ones; REM/REMU SHALL return DataA.
REQ-026 Signed overflow (DIV/REM with DataA = most-negative and DataB = -1): DIV SHALL return DataA; REM SHALL return 0.
REQ-027 Signed divide SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-028 The full product SHALL be 2*WIDTH_DATA_LENGTH bits; MUL results SHALL be identical for signed and unsigned operands.

Reset
REQ-029 On rst=1, asynchronously: state SHALL be IDLE, Busy=0, Valid=0, DataOut=0, and all internal registers SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation with no Valid pulse.
REQ-031 After rst deasserts, the first edge SHALL be able to accept Start.

Structure
REQ-032 A shared package SHALL hold the MDSel encodings, the FSM state enum and the default width constants.
REQ-033 The combinational single radix-2 add/subtract-shift step SHALL be the sub-module mul_div_step; the FSM, counter and sign fix SHALL stay in mul_div_unit.

Verification
REQ-034 MUL with DataA=100, DataB=456 -> DataOut=45600 (0x0000B220), Valid exactly 34 cycles after Start.
REQ-035 DIV and REM with DataA=-100, DataB=-1235 -> DIV=0 and REM=-100 (0xFFFFFF9C); MULH with the same operands -> 0x00000000.
REQ-036 MULHU with DataA=DataB=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU with the same operands -> 0xFFFFFFFF.
REQ-037 DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-038 Flush at CALC cycle 10 -> no Valid and DataOut unchanged; Start on the following cycle completes normally.
REQ-039 rst pulse at CALC cycle 20 -> outputs 0 immediately and no Valid; Start held high during Busy is ignored, giving a single Valid pulse.
